trap_return_ctrl: RTL and testbench

TRAP_RETURN_CTRL -- requirements
Module: trap_return_ctrl

---
 rtl/trap_return_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_trap_return_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/trap_return_ctrl.sv
// MRET return sequencer: drains older instructions, redirects fetch to the saved
// return PC, restores MIE from MPIE, then masks interrupts for a short shadow.
module trap_return_ctrl #(
    parameter int XLEN          = 32,
    parameter int DEPTH_W       = 2,
    parameter int SHADOW_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mret_valid,
    input  logic [XLEN-1:0]    mepc_in,
    input  logic               mpie_in,
    input  logic               mem_valid,
    input  logic               wb_valid,
    input  logic               exception_valid,
    input  logic               pipeline_stall,
    input  logic               trap_busy,
    input  logic               trap_taken,
    output logic               pc_redirect,
    output logic [XLEN-1:0]    redirect_pc,
    output logic               flush_if,
    output logic               flush_id,
    output logic               flush_ex,
    output logic               csr_wr,
    output logic               mie_new,
    output logic               mpie_new,
    output logic               irq_mask,
    output logic               ret_busy,
    output logic               mret_done,
    output logic               illegal_mret,
    output logic [DEPTH_W-1:0] depth
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_REDIRECT,
        ST_SHADOW
    } state_t;

    localparam logic [3:0] SHADOW_LOAD = 4'(SHADOW_CYCLES);

    state_t              r_state;
    logic [XLEN-1:0]     r_target;
    logic                r_mpie;
    logic [3:0]          r_shadow_cnt;
    logic [DEPTH_W-1:0]  r_depth;

    logic                r_pc_redirect;
    logic                r_flush;
    logic                r_csr_wr;
    logic                r_mie_new;
    logic                r_mpie_new;
    logic                r_irq_mask;
    logic                r_ret_busy;
    logic                r_mret_done;
    logic                r_illegal_mret;

    logic                w_accept;
    logic                w_depth_zero;
    logic                w_depth_max;
    logic                w_ret_commit;
    logic                w_drain_done;
    logic [XLEN-1:0]     w_aligned_pc;

    assign w_accept     = (r_state == ST_IDLE) && mret_valid && !pipeline_stall
                          && !trap_busy && !exception_valid;
    assign w_depth_zero = (r_depth == '0);
    assign w_depth_max  = (r_depth == '1);
    assign w_ret_commit = (r_state == ST_REDIRECT);
    assign w_drain_done = !mem_valid && !wb_valid && !exception_valid && !pipeline_stall;
    assign w_aligned_pc = {mepc_in[XLEN-1:2], 2'b00};

    // The return's decrement lands at the end of the REDIRECT cycle so that a
    // trap entering in that same cycle cancels it out exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_depth <= '0;
        end else if (trap_taken && !w_ret_commit) begin
            if (!w_depth_max) begin
                r_depth <= r_depth + 1'b1;
            end
        end else if (!trap_taken && w_ret_commit && !w_depth_zero) begin
            r_depth <= r_depth - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_target       <= '0;
            r_mpie         <= 1'b0;
            r_shadow_cnt   <= '0;
            r_pc_redirect  <= 1'b0;
            r_flush        <= 1'b0;
            r_csr_wr       <= 1'b0;
            r_mie_new      <= 1'b0;
            r_mpie_new     <= 1'b0;
            r_irq_mask     <= 1'b0;
            r_ret_busy     <= 1'b0;
            r_mret_done    <= 1'b0;
            r_illegal_mret <= 1'b0;
        end else begin
            r_pc_redirect  <= 1'b0;
            r_flush        <= 1'b0;
            r_csr_wr       <= 1'b0;
            r_mie_new      <= 1'b0;
            r_mpie_new     <= 1'b0;
            r_irq_mask     <= 1'b0;
            r_ret_busy     <= 1'b0;
            r_mret_done    <= 1'b0;
            r_illegal_mret <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_depth_zero) begin
                            r_illegal_mret <= 1'b1;
                        end else begin
                            r_target   <= w_aligned_pc;
                            r_mpie     <= mpie_in;
                            r_state    <= ST_DRAIN;
                            r_ret_busy <= 1'b1;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (exception_valid) begin
                        r_state <= ST_IDLE;
                    end else if (w_drain_done) begin
                        r_state       <= ST_REDIRECT;
                        r_ret_busy    <= 1'b1;
                        r_pc_redirect <= 1'b1;
                        r_flush       <= 1'b1;
                        r_csr_wr      <= 1'b1;
                        r_mie_new     <= r_mpie;
                        r_mpie_new    <= 1'b1;
                        r_mret_done   <= 1'b1;
                    end else begin
                        r_ret_busy <= 1'b1;
                    end
                end

                // Never stretched by a stall: the redirect is a single-cycle event.
                ST_REDIRECT: begin
                    r_state      <= ST_SHADOW;
                    r_shadow_cnt <= SHADOW_LOAD;
                    r_irq_mask   <= 1'b1;
                    r_ret_busy   <= 1'b1;
                end

                ST_SHADOW: begin
                    if (pipeline_stall) begin
                        r_irq_mask <= 1'b1;
                        r_ret_busy <= 1'b1;
                    end else if (r_shadow_cnt <= 4'd1) begin
                        r_state      <= ST_IDLE;
                        r_shadow_cnt <= '0;
                    end else begin
                        r_shadow_cnt <= r_shadow_cnt - 4'd1;
                        r_irq_mask   <= 1'b1;
                        r_ret_busy   <= 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pc_redirect  = r_pc_redirect;
    assign redirect_pc  = r_target;
    assign flush_if     = r_flush;
    assign flush_id     = r_flush;
    assign flush_ex     = r_flush;
    assign csr_wr       = r_csr_wr;
    assign mie_new      = r_mie_new;
    assign mpie_new     = r_mpie_new;
    assign irq_mask     = r_irq_mask;
    assign ret_busy     = r_ret_busy;
    assign mret_done    = r_mret_done;
    assign illegal_mret = r_illegal_mret;
    assign depth        = r_depth;

endmodule

// File: tb/tb_trap_return_ctrl.sv
// Cycle-vector bench for trap_return_ctrl: each record drives one cycle of inputs
// and lists the outputs expected just after the following rising edge.
module tb_trap_return_ctrl;

    logic        clk = 1'b0;
    logic        rst, mret_valid, mpie_in, mem_valid, wb_valid;
    logic        exception_valid, pipeline_stall, trap_busy, trap_taken;
    logic [31:0] mepc_in;
    logic        pc_redirect, flush_if, flush_id, flush_ex, csr_wr;
    logic        mie_new, mpie_new, irq_mask, ret_busy, mret_done, illegal_mret;
    logic [31:0] redirect_pc;
    logic [1:0]  depth;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    trap_return_ctrl #(.XLEN(32), .DEPTH_W(2), .SHADOW_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .mret_valid(mret_valid), .mepc_in(mepc_in),
        .mpie_in(mpie_in), .mem_valid(mem_valid), .wb_valid(wb_valid),
        .exception_valid(exception_valid), .pipeline_stall(pipeline_stall),
        .trap_busy(trap_busy), .trap_taken(trap_taken),
        .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
        .flush_if(flush_if), .flush_id(flush_id), .flush_ex(flush_ex),
        .csr_wr(csr_wr), .mie_new(mie_new), .mpie_new(mpie_new),
        .irq_mask(irq_mask), .ret_busy(ret_busy), .mret_done(mret_done),
        .illegal_mret(illegal_mret), .depth(depth)
    );

    typedef struct {
        string       tag;
        logic        rst, mret, mpie, mem, wb, exc, stall, tbusy, ttaken;
        logic [31:0] mepc;
        logic        redir, mie, mask, busy, ill;
        logic [1:0]  dep;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string tag, input logic r, input logic m, input logic [31:0] epc,
                       input logic mp, input logic me, input logic w, input logic ex,
                       input logic st, input logic tb, input logic tt,
                       input logic redir, input logic mie, input logic mask,
                       input logic busy, input logic ill, input logic [1:0] dep,
                       input logic [31:0] pc);
        vec_t v;
        v.tag = tag; v.rst = r; v.mret = m; v.mepc = epc; v.mpie = mp; v.mem = me;
        v.wb = w; v.exc = ex; v.stall = st; v.tbusy = tb; v.ttaken = tt;
        v.redir = redir; v.mie = mie; v.mask = mask; v.busy = busy; v.ill = ill;
        v.dep = dep; v.pc = pc;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic m, input logic [31:0] epc, input logic mp,
                         input logic me, input logic w, input logic ex, input logic st,
                         input logic tb, input logic tt);
        @(negedge clk);
        rst = r; mret_valid = m; mepc_in = epc; mpie_in = mp; mem_valid = me;
        wb_valid = w; exception_valid = ex; pipeline_stall = st; trap_busy = tb;
        trap_taken = tt;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [12:0] flags_now();
        return {pc_redirect, flush_if, flush_id, flush_ex, csr_wr, mie_new, mpie_new,
                irq_mask, ret_busy, mret_done, illegal_mret, depth};
    endfunction

    initial begin
        logic [12:0] exp_flags;
        int          redir_cycles;
        bit          seen;

        rst = 1'b1; mret_valid = 0; mepc_in = '0; mpie_in = 0; mem_valid = 0;
        wb_valid = 0; exception_valid = 0; pipeline_stall = 0; trap_busy = 0; trap_taken = 0;

        //    tag            rst mret mepc         mpie mem wb exc stl tbz tt | rd mie msk bsy ill dep pc
        add("reset",          1, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 32'h0);
        add("illegal",        0, 1, 32'h2004,     0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 32'h0);
        add("illegal_end",    0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 32'h0);
        add("trap_d1",        0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 32'h0);
        add("mret_accept",    0, 1, 32'h1003,     1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 1, 32'h1000);
        add("redirect",       0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 1, 0, 1, 32'h1000);
        add("shadow1_ignore", 0, 1, 32'h5000,     0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 32'h1000);
        add("shadow2",        0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 32'h1000);
        add("back_idle",      0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 32'h1000);
        add("trap_d1b",       0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 32'h1000);
        add("trap_d2",        0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 2, 32'h1000);
        add("mret_wb",        0, 1, 32'h3008,     0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 2, 32'h3008);
        add("drain_wb1",      0, 0, 32'h0,        0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 2, 32'h3008);
        add("drain_wb2",      0, 0, 32'h0,        0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 2, 32'h3008);
        add("drain_wb3",      0, 0, 32'h0,        0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 2, 32'h3008);
        add("redirect_wb",    0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 2, 32'h3008);
        add("shadow_d1",      0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 1, 32'h3008);
        add("shadow_stall",   0, 0, 32'h0,        0, 0, 0, 0, 1, 0, 0,  0, 0, 1, 1, 0, 1, 32'h3008);
        add("shadow_last",    0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 1, 32'h3008);
        add("idle_d1",        0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 32'h3008);
        add("mret_abort",     0, 1, 32'h4000,     1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 1, 32'h4000);
        add("drain_exc",      0, 0, 32'h0,        0, 1, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 1, 32'h4000);
        add("after_abort",    0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 32'h4000);
        add("blk_trapbusy",   0, 1, 32'h4444,     1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 1, 32'h4000);
        add("blk_stall",      0, 1, 32'h4444,     1, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 1, 32'h4000);
        add("blk_exc",        0, 1, 32'h4444,     1, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 1, 32'h4000);
        add("mret_6001",      0, 1, 32'h6001,     0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 1, 32'h6000);
        add("drain_stall",    0, 0, 32'h0,        0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 0, 1, 32'h6000);
        add("redirect_6000",  0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 1, 32'h6000);
        add("trap_in_redir",  0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 1, 0, 1, 32'h6000);
        add("shadow_net",     0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 1, 32'h6000);
        add("idle_net",       0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 32'h6000);
        add("reset2",         1, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 32'h0);
        add("sat_1",          0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 32'h0);
        add("sat_2",          0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 2, 32'h0);
        add("sat_3",          0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 3, 32'h0);
        add("sat_4",          0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 3, 32'h0);
        add("mret_d3",        0, 1, 32'h7000,     1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 3, 32'h7000);
        add("drain_trap_sat", 0, 0, 32'h0,        0, 1, 0, 0, 0, 0, 1,  0, 0, 0, 1, 0, 3, 32'h7000);
        add("redirect_d3",    0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 1, 0, 3, 32'h7000);
        add("shadow_d2",      0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 2, 32'h7000);
        add("shadow_stall2",  0, 0, 32'h0,        0, 0, 0, 0, 1, 0, 0,  0, 0, 1, 1, 0, 2, 32'h7000);
        add("rst_in_shadow",  1, 0, 32'h0,        0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 32'h0);
        add("post_rst_a",     0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 32'h0);
        add("trap_d1c",       0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 32'h0);
        add("mret_8000",      0, 1, 32'h8000,     1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 1, 32'h8000);
        add("rst_in_drain",   1, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 32'h0);
        add("post_rst_b",     0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 32'h0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].mret, vecs[i].mepc, vecs[i].mpie, vecs[i].mem,
                  vecs[i].wb, vecs[i].exc, vecs[i].stall, vecs[i].tbusy, vecs[i].ttaken);
            exp_flags = {vecs[i].redir, vecs[i].redir, vecs[i].redir, vecs[i].redir,
                         vecs[i].redir, vecs[i].mie, vecs[i].redir, vecs[i].mask,
                         vecs[i].busy, vecs[i].redir, vecs[i].ill, vecs[i].dep};
            check($sformatf("%s.flags", vecs[i].tag), 32'(flags_now()), 32'(exp_flags));
            check($sformatf("%s.pc", vecs[i].tag), redirect_pc, vecs[i].pc);
            $display("vec %0d %s flags=%b pc=0x%0h", i, vecs[i].tag, flags_now(), redirect_pc);
        end

        // Stall asserted right after the redirect: the redirect must stay one cycle
        // and the shadow must hold irq_mask until the stall lifts.
        drive(1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 1, 32'h9abf, 1, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 32'h0, 0, 1, 0, 0, 0, 0, 0);
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            drive(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
            if (pc_redirect) seen = 1;
        end
        check("seq.redirect_seen", 32'(seen), 32'd1);
        check("seq.redirect_pc", redirect_pc, 32'h9abc);
        redir_cycles = 0;
        for (int c = 0; c < 5; c++) begin
            drive(0, 0, 32'h0, 0, 0, 0, 0, 1, 0, 0);
            if (pc_redirect) redir_cycles++;
        end
        check("seq.redirect_not_stretched", 32'(redir_cycles), 32'd0);
        check("seq.mask_held_in_stall", 32'(irq_mask), 32'd1);
        check("seq.depth_after_return", 32'(depth), 32'd0);
        drive(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        check("seq.mask_last_cycle", 32'(irq_mask), 32'd1);
        drive(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        check("seq.busy_released", 32'(ret_busy), 32'd0);
        check("seq.mask_released", 32'(irq_mask), 32'd0);
        $display("seq stall_after_redirect redir_cycles=%0d busy=%0b", redir_cycles, ret_busy);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
